imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_word_assembler.sv | 40 ++++
 rtl/imem_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
//   state_t        - loader FSM states
//   BYTES_PER_WORD - stream bytes assembled into one instruction word
//   LEN_BYTES      - bytes in the little-endian word-count header
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHECK
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_BYTES      = 2;

endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs stream bytes little-endian into a 32-bit word.
//   clk, rst_n   - clock, asynchronous active-low reset
//   i_clear      - restart assembly at byte 0 and zero the word
//   i_byte_en    - accept i_byte this cycle
//   i_byte       - incoming byte
//   o_word       - assembled word (first byte in [7:0], fourth in [31:24])
//   o_word_full  - high in the cycle the fourth byte is accepted
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    // Shifting in from the top leaves the first byte in [7:0] after four shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_byte_en) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= {i_byte, r_word[31:8]};
        end
    end

    assign o_word      = r_word;
    assign o_word_full = i_byte_en && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream and writes it into instruction RAM.
// Frame: LEN_LO, LEN_HI (word count N), 4*N data bytes, XOR checksum byte.
//   clk, rst_n  - clock, asynchronous active-low reset
//   load_start  - pulse in IDLE opens a load session
//   rx_data/rx_valid/rx_ready - byte stream handshake
//   mem_we/mem_waddr/mem_wdata - one-cycle word write to the RAM
//   cpu_hold    - holds the core in reset during a session
//   done/error  - outcome of the last session (levels)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned IDX_W = $clog2(DEPTH) + 1;

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_len;
    logic [IDX_W-1:0] r_index;
    logic [7:0]       r_csum;
    logic             r_cpu_hold;
    logic             r_done;
    logic             r_error;

    logic             w_xfer;
    logic [15:0]      w_len;
    logic             w_oversize;
    logic             w_last;
    logic             w_clear;
    logic             w_byte_en;
    logic [31:0]      w_word;
    logic             w_word_full;

    assign w_xfer     = rx_valid && rx_ready;
    assign w_len      = {rx_data, r_len[7:0]};
    assign w_oversize = w_len > 16'(DEPTH);
    assign w_last     = (16'(r_index) + 16'd1) == r_len;

    imem_word_assembler u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_clear),
        .i_byte_en   (w_byte_en),
        .i_byte      (rx_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        rx_ready  = 1'b0;
        mem_we    = 1'b0;
        w_clear   = 1'b0;
        w_byte_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_start) begin
                    w_clear = 1'b1;
                    w_next  = LEN_LO;
                end
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                if (w_xfer) w_next = LEN_HI;
            end
            LEN_HI: begin
                rx_ready = 1'b1;
                if (w_xfer) begin
                    if (w_oversize)        w_next = IDLE;
                    else if (w_len == '0)  w_next = CHECK;
                    else                   w_next = DATA;
                end
            end
            DATA: begin
                rx_ready  = 1'b1;
                w_byte_en = w_xfer;
                if (w_word_full) w_next = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
                w_next = w_last ? CHECK : DATA;
            end
            CHECK: begin
                rx_ready = 1'b1;
                if (w_xfer) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_index    <= '0;
            r_csum     <= '0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_start) begin
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_index    <= '0;
                        r_csum     <= '0;
                        r_len      <= '0;
                    end
                end
                LEN_LO: begin
                    if (w_xfer) begin
                        r_len[7:0] <= rx_data;
                        r_csum     <= r_csum ^ rx_data;
                    end
                end
                LEN_HI: begin
                    if (w_xfer) begin
                        r_len  <= w_len;
                        r_csum <= r_csum ^ rx_data;
                        if (w_oversize) begin
                            r_error    <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (w_xfer) r_csum <= r_csum ^ rx_data;
                end
                WRITE: begin
                    r_index <= r_index + 1'b1;
                end
                CHECK: begin
                    if (w_xfer) begin
                        if (rx_data == r_csum) r_done  <= 1'b1;
                        else                   r_error <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_waddr = BASE_ADDR + (32'(r_index) << 2);
    assign mem_wdata = w_word;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(64), .BASE_ADDR(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write monitor: one entry per cycle with mem_we high.
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_waddr);
            wr_data.push_back(mem_wdata);
        end
    end

    logic [7:0]  fr[$];
    logic [31:0] ew[$];

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap_pct);
        bit sent = 0;
        for (int t = 0; t < 500 && !sent; t++) begin
            @(negedge clk);
            if ($urandom_range(99) < gap_pct) begin
                rx_valid = 1'b0;
            end else begin
                rx_valid = 1'b1;
                rx_data  = b;
                #1;
                if (rx_ready) begin
                    @(posedge clk);
                    #1;
                    rx_valid = 1'b0;
                    sent = 1;
                end
            end
        end
        if (!sent) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input int unsigned gap_pct);
        foreach (fr[i]) send_byte(fr[i], gap_pct);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic verify_writes(input string tag);
        int unsigned n;
        chk({tag, "_wr_count"}, wr_addr.size(), ew.size());
        n = (wr_addr.size() < ew.size()) ? wr_addr.size() : ew.size();
        for (int unsigned i = 0; i < n; i++) begin
            chk({tag, "_waddr"}, wr_addr[i], 32'(i * 4));
            chk({tag, "_wdata"}, wr_data[i], ew[i]);
        end
    endtask

    task automatic verify_end(input string tag, input logic exp_done, input logic exp_err);
        chk({tag, "_done"},     done,     exp_done);
        chk({tag, "_error"},    error,    exp_err);
        chk({tag, "_cpu_hold"}, cpu_hold, 1'b0);
        chk({tag, "_rx_ready"}, rx_ready, 1'b0);
    endtask

    task automatic load_nominal_frame(input logic [7:0] csum);
        fr = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, csum};
        ew = '{32'h0050_0093, 32'h0010_0113};
    endtask

    initial begin
        logic [7:0] cs;

        rst_n      = 1'b0;
        load_start = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        #1;
        chk("rst_rx_ready",  rx_ready,  1'b0);
        chk("rst_mem_we",    mem_we,    1'b0);
        chk("rst_waddr",     mem_waddr, 32'h0);
        chk("rst_wdata",     mem_wdata, 32'h0);
        chk("rst_cpu_hold",  cpu_hold,  1'b0);
        chk("rst_done",      done,      1'b0);
        chk("rst_error",     error,     1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Nominal two-word load.
        clear_log();
        load_nominal_frame(8'hC3);
        pulse_start();
        #1;
        chk("nom_hold_on", cpu_hold, 1'b1);
        send_frame(0);
        verify_writes("nom");
        verify_end("nom", 1'b1, 1'b0);

        // Bad checksum: words still written, error reported.
        clear_log();
        load_nominal_frame(8'hC2);
        pulse_start();
        send_frame(0);
        verify_writes("badcs");
        verify_end("badcs", 1'b0, 1'b1);

        // Oversize length aborts right after LEN_HI.
        clear_log();
        ew.delete();
        fr = '{8'h41, 8'h00};
        pulse_start();
        send_frame(0);
        verify_end("over", 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("over_rx_ready_later", rx_ready, 1'b0);
        verify_writes("over");

        // N=0 with checksum 00.
        clear_log();
        ew.delete();
        fr = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        send_frame(0);
        verify_writes("n0");
        verify_end("n0", 1'b1, 1'b0);

        // N=DEPTH with random data and 50% valid gaps.
        clear_log();
        ew.delete();
        fr = '{8'h40, 8'h00};
        for (int i = 0; i < 64; i++) ew.push_back($urandom);
        foreach (ew[i]) for (int k = 0; k < 4; k++) fr.push_back(ew[i][8*k +: 8]);
        cs = 8'h00;
        foreach (fr[i]) cs = cs ^ fr[i];
        fr.push_back(cs);
        pulse_start();
        send_frame(50);
        verify_writes("full");
        verify_end("full", 1'b1, 1'b0);

        // Reset after 6 data bytes: one word written, outputs drop asynchronously.
        clear_log();
        fr = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
        pulse_start();
        send_frame(0);
        chk("mid_hold", cpu_hold, 1'b1);
        chk("mid_wr_count", wr_addr.size(), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rx_ready", rx_ready,  1'b0);
        chk("mid_rst_mem_we",   mem_we,    1'b0);
        chk("mid_rst_waddr",    mem_waddr, 32'h0);
        chk("mid_rst_wdata",    mem_wdata, 32'h0);
        chk("mid_rst_cpu_hold", cpu_hold,  1'b0);
        chk("mid_rst_done",     done,      1'b0);
        chk("mid_rst_error",    error,     1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        load_nominal_frame(8'hC3);
        pulse_start();
        send_frame(0);
        verify_writes("reload");
        verify_end("reload", 1'b1, 1'b0);

        // rx_valid in IDLE is not consumed; load_start during DATA is ignored.
        clear_log();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'hAA;
            #1;
            chk("idle_rx_ready", rx_ready, 1'b0);
        end
        rx_valid = 1'b0;
        load_nominal_frame(8'hC3);
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(fr[i], 0);
        pulse_start();
        #1;
        chk("ign_hold", cpu_hold, 1'b1);
        for (int i = 4; i < 11; i++) send_byte(fr[i], 0);
        verify_writes("ign");
        verify_end("ign", 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
